// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes of a captured 128-bit
// state per cycle through the FIPS-197 inverse S-box, with valid/ready on both sides.
module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC  = 16 / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    // Inverse S-box, row-major: entry b sits at bits [8*b +: 8] of an ascending vector.
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       work_q;
    logic [127:0]       work_d;
    logic [127:0]       out_state_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               in_ready_q;

    always_comb begin
        // NOTE: default the whole vector first so only the active lanes change and no latch is inferred.
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[8*((int'(cnt_q) * LANES + l) & 15) +: 8] =
                inv_sbox(work_q[8*((int'(cnt_q) * LANES + l) & 15) +: 8]);
        end
    end

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    // The final lane group finishes the block in the same cycle it is substituted.
                    if (cnt_q == CNT_LAST) begin
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed and round-trip bench for inv_subbytes_seq at LANES = 4, 1 and 16.
module tb_inv_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_state;
    logic         out_ready;

    logic         in_valid4, in_ready4, out_valid4, busy4;
    logic [127:0] out_state4;
    logic         in_valid1, in_ready1, out_valid1, busy1;
    logic [127:0] out_state1;
    logic         in_valid16, in_ready16, out_valid16, busy16;
    logic [127:0] out_state16;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_sbox [256];

    always #5 clk = ~clk;

    inv_subbytes_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state),
        .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
    );
    inv_subbytes_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state),
        .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1), .busy(busy1)
    );
    inv_subbytes_seq #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_state(in_state),
        .out_valid(out_valid16), .out_ready(out_ready), .out_state(out_state16), .busy(busy16)
    );

    // Forward S-box built from GF(2^8) inversion plus the affine map, independent of the DUT table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Drives one block into the LANES=4 instance and waits for out_valid; caller is in IDLE at posedge+1.
    task automatic send_block(input logic [127:0] st, output logic [127:0] res, output int lat);
        in_state  = st;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy4); end
        checks++; if (out_state4 !== 128'h0) begin errors++; $display("FAIL reset_out_state got %h exp 0", out_state4); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got rdy=%b vld=%b exp rdy=1 vld=0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_uniform();
        logic [127:0] res;
        int lat;
        out_ready = 1'b0;
        send_block({16{8'h63}}, res, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL uniform63_latency got %0d exp 4", lat); end
        checks++; if (res !== 128'h0) begin errors++; $display("FAIL uniform63_data got %h exp 0", res); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++; $display("FAIL uniform63_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid4, in_ready4);
        end
        send_block({16{8'h00}}, res, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL uniform00_latency got %0d exp 4", lat); end
        checks++; if (res !== {16{8'h52}}) begin errors++; $display("FAIL uniform00_data got %h exp %h", res, {16{8'h52}}); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_mixed();
        logic [127:0] st, exp_st, res;
        int lat;
        st = {16{8'h63}};
        st[7:0] = 8'hd4; st[15:8] = 8'h16; st[23:16] = 8'h7c; st[127:120] = 8'hff;
        exp_st = 128'h0;
        exp_st[7:0] = 8'h19; exp_st[15:8] = 8'hff; exp_st[23:16] = 8'h01; exp_st[127:120] = 8'h7d;
        send_block(st, res, lat);
        checks++; if (res !== exp_st) begin errors++; $display("FAIL mixed_lanes got %h exp %h", res, exp_st); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        int lat;
        out_ready = 1'b0;
        send_block({16{8'h16}}, res, lat);
        for (int i = 0; i < 10; i++) begin
            in_state  = {16{8'h00}};
            in_valid4 = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, out_valid4); end
            checks++; if (out_state4 !== {16{8'hff}}) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h exp all ff", i, out_state4); end
            checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready4); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid4, in_ready4);
        end
        checks++; if (out_state4 !== {16{8'hff}}) begin errors++; $display("FAIL bp_release_data got %h exp all ff", out_state4); end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        checks++; if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
            errors++; $display("FAIL bp_new_accept got busy=%b rdy=%b exp busy=1 rdy=0", busy4, in_ready4);
        end
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_new_latency got %0d exp 4", lat); end
        checks++; if (out_state4 !== {16{8'h52}}) begin errors++; $display("FAIL bp_new_data got %h exp all 52", out_state4); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic seen;
        in_state  = {16{8'h63}};
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy4); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy4); end
        checks++; if (out_state4 !== 128'h0) begin errors++; $display("FAIL midrst_out_state got %h exp 0", out_state4); end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid4) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_discard got out_valid=1 exp none"); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL midrst_idle got rdy=%b exp 1", in_ready4); end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig, st, got1, got4, got16;
        int lat1, lat4, lat16;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int b = 0; b < 16; b++) st[8*b +: 8] = fwd_sbox[orig[8*b +: 8]];
            in_state   = st;
            in_valid1  = 1'b1;
            in_valid4  = 1'b1;
            in_valid16 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0; in_valid4 = 1'b0; in_valid16 = 1'b0;
            lat1 = 0; lat4 = 0; lat16 = 0;
            got1 = 'x; got4 = 'x; got16 = 'x;
            for (int c = 1; c <= 20; c++) begin
                if (c > 1) begin
                    @(posedge clk); #1;
                end else begin
                    @(posedge clk); #1;
                    checks++; if (busy1 !== 1'b1 || busy16 !== 1'b0) begin
                        errors++; $display("FAIL rt_busy iter %0d got busy1=%b busy16=%b exp 1 0", n, busy1, busy16);
                    end
                end
                if (lat1 == 0 && out_valid1) begin lat1 = c; got1 = out_state1; end
                if (lat4 == 0 && out_valid4) begin lat4 = c; got4 = out_state4; end
                if (lat16 == 0 && out_valid16) begin lat16 = c; got16 = out_state16; end
            end
            checks++; if (lat1 !== 16) begin errors++; $display("FAIL rt_lat_l1 iter %0d got %0d exp 16", n, lat1); end
            checks++; if (lat4 !== 4) begin errors++; $display("FAIL rt_lat_l4 iter %0d got %0d exp 4", n, lat4); end
            checks++; if (lat16 !== 1) begin errors++; $display("FAIL rt_lat_l16 iter %0d got %0d exp 1", n, lat16); end
            checks++; if (got1 !== orig) begin errors++; $display("FAIL rt_data_l1 iter %0d got %h exp %h", n, got1, orig); end
            checks++; if (got4 !== orig) begin errors++; $display("FAIL rt_data_l4 iter %0d got %h exp %h", n, got4, orig); end
            checks++; if (got16 !== orig) begin errors++; $display("FAIL rt_data_l16 iter %0d got %h exp %h", n, got16, orig); end
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [127:0] b2b_in(input int j);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = fwd_sbox[16*j + i];
        return v;
    endfunction

    function automatic logic [127:0] b2b_exp(input int j);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(16*j + i);
        return v;
    endfunction

    task automatic test_back_to_back();
        int idx_in = 0;
        int idx_out = 0;
        int cyc = 0;
        int last_out = 0;
        logic hs_in, hs_out;
        out_ready = 1'b1;
        in_state  = b2b_in(0);
        in_valid4 = 1'b1;
        while (idx_out < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            hs_in  = in_valid4 && in_ready4;
            hs_out = out_valid4 && out_ready;
            if (hs_out) begin
                checks++; if (out_state4 !== b2b_exp(idx_out)) begin
                    errors++; $display("FAIL b2b_data blk %0d got %h exp %h", idx_out, out_state4, b2b_exp(idx_out));
                end
                if (idx_out > 0) begin
                    checks++; if (cyc - last_out !== 6) begin
                        errors++; $display("FAIL b2b_period blk %0d got %0d exp 6", idx_out, cyc - last_out);
                    end
                end
                last_out = cyc;
                idx_out++;
            end
            @(posedge clk); #1;
            if (hs_in) begin
                idx_in++;
                if (idx_in >= 6) in_valid4 = 1'b0;
                else in_state = b2b_in(idx_in);
            end
        end
        in_valid4 = 1'b0;
        out_ready = 1'b0;
        checks++; if (idx_out !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", idx_out); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_state   = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        build_sbox();
        test_reset();
        test_uniform();
        test_mixed();
        test_backpressure();
        test_reset_mid_busy();
        test_round_trip();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
